muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit; sits beside the single-cycle ALU on the same `a`/`b` operand buses.
- Handles the M-extension operations the ALU does not: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses an iterative shift-add multiplier and a restoring divider, with a start/busy/done handshake.
- The core stalls on `busy` and writes `r` back when `done` pulses.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RV32M multiply/divide unit (shift-add multiplier,
//               restoring divider). Optional MULDIV_FAST_MUL_EN selects a
//               single-cycle multiplier.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [5:0]      c_last = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_funct3;
  logic [5:0]          r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mcand;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [XLEN-1:0]     r_r;

  logic                w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag, w_fast_r, w_run_r, w_quo_fix, w_rem_fix;
  logic                w_div_zero, w_div_ovf, w_fast_mul, w_fast, w_last;
  logic [2*XLEN-1:0]   w_fprod, w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod_fix;
  logic [XLEN:0]       w_mul_sum, w_rem_sh, w_trial;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && a[XLEN-1];
  assign w_b_neg    = w_b_signed && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
  assign w_div_zero = funct3[2] && (b == '0);
  assign w_div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) && (a == c_min) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fa, w_fb;
  assign w_fa       = w_a_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
  assign w_fb       = w_b_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast_mul = ~funct3[2];
`else
  assign w_fprod    = '0;
  assign w_fast_mul = 1'b0;
`endif

  assign w_fast = w_div_zero || w_div_ovf || w_fast_mul;

  always_comb begin
    w_fast_r = '0;
    if (w_div_zero)
      w_fast_r = funct3[1] ? a : '1;
    else if (w_div_ovf)
      w_fast_r = funct3[1] ? '0 : c_min;
    else if (w_fast_mul)
      w_fast_r = (funct3 == 3'b000) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
  end

  // Multiply: r_acc = {partial product, remaining multiplier bits}
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: r_acc = {remainder, dividend bits shifting into quotient}
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_trial   = w_rem_sh - {1'b0, r_mcand};
  assign w_div_nxt = w_trial[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_nxt = r_funct3[2] ? w_div_nxt : w_mul_nxt;

  assign w_prod_fix = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_quo_fix  = r_neg_q ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
  assign w_rem_fix  = r_neg_r ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1) : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_run_r = '0;
    case (r_funct3)
      3'b000:                 w_run_r = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_run_r = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_run_r = w_quo_fix;
      default:                w_run_r = w_rem_fix;
    endcase
  end

  assign w_last = (r_state == S_RUN) && (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_fast ? S_FIN : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        if (start) w_state_nxt = w_fast ? S_FIN : S_RUN;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3 <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_r      <= '0;
    end else if (w_accept) begin
      r_funct3 <= funct3;
      r_cnt    <= '0;
      r_mcand  <= funct3[2] ? w_b_mag : w_a_mag;
      r_acc    <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (w_fast) r_r <= w_fast_r;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 6'd1;
      if (w_last) r_r <= w_run_r;
    end
  end

  assign r = r_r;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit; arithmetic reference
//               model plus directed vectors with hand-computed results.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] r;

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en  = 1'b0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .r(r)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // RV32M semantics straight from the ISA definition
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (f)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return 32'($signed(x) / $signed(y));
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        return 32'($signed(x) % $signed(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int m_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) return MUL_LAT;
    if (y == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Model: m_cnt = cycles left in the current op including this one (1 = done cycle)
  int          m_cnt = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_r = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_r   = '0;
    end else if (m_cnt <= 1 && start) begin
      m_cnt  = m_lat(funct3, a, b);
      m_pend = ref_op(funct3, a, b);
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
    if (!rst && m_cnt == 1) m_r = m_pend;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_cnt > 1)});
      chk("done", {31'd0, done}, {31'd0, (m_cnt == 1)});
      chk("r",    r, m_r);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        return;
      end
    end
    nchecks++;
    nerrors++;
    $display("FAIL wait_done: got no done within 40 cycles expected done");
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    issue(f, x, y);
    wait_done(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_r"}, r, exp_r);
  endtask

  logic [31:0] vals [8] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                            32'd7, 32'hFFFFFFEC, 32'd6, 32'h12345678};

  initial begin
    int lat, ndone;
    logic [2:0]  f;
    logic [31:0] x, y;

    chk("pin_mul",    ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("pin_mulh",   ref_op(3'd1, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFFF);
    chk("pin_mulhsu", ref_op(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    chk("pin_rem",    ref_op(3'd6, 32'hFFFFFFEC, 32'd6), 32'hFFFFFFFE);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_r", r, 32'd0);

    run_op("mul",   3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh",  3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, MUL_LAT);
    run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("div",   3'd4, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 33);
    run_op("rem",   3'd6, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 33);
    run_op("divu",  3'd5, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 33);
    run_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_z",  3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
`ifdef MULDIV_FAST_MUL_EN
    run_op("fmul",   3'd0, 32'h10000, 32'h10000, 32'd0, 1);
    run_op("fmulhu", 3'd3, 32'h10000, 32'h10000, 32'd1, 1);
`endif

    // start pulses while iterating must be ignored
    issue(3'd4, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    chk("ignore_r", r, 32'd14);
    repeat (36) @(negedge clk);

    // back-to-back: start held during the done cycle
    issue(3'd5, 32'hFFFFFFFF, 32'd2);
    wait_done(lat);
    start = 1'b1; funct3 = 3'd6; a = 32'hFFFFFFEC; b = 32'd6;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_r", r, 32'hFFFFFFFE);

    // reset mid-divide, with a coincident start that must be dropped
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_r", r, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      x = (i % 2 == 0) ? vals[$urandom_range(0, 7)] : $urandom;
      y = (i % 3 == 0) ? vals[$urandom_range(0, 7)] : $urandom;
      run_op("rand", f, x, y, ref_op(f, x, y), m_lat(f, x, y));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
